// File: rtl/player_input_ctrl_if.sv
// ============================================================================
// Module      : player_input_ctrl_if
// Description : One-entry movement-step valid/ready channel toward game logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface player_input_ctrl_if;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;

    modport master (
        output move_valid,
        output move_dir,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_dir,
        output move_ready
    );
endinterface

`default_nettype wire

// File: rtl/player_input_ctrl.sv
// ============================================================================
// Module      : player_input_ctrl
// Description : Frame-paced direction auto-repeat, step delivery and chop pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_input_ctrl #(
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 4
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    input  wire logic         vsync,
    input  wire logic         pause,
    input  wire logic         up,
    input  wire logic         down,
    input  wire logic         left,
    input  wire logic         right,
    input  wire logic         chop,
    player_input_ctrl_if.master mv,
    output logic [1:0]        player_direction,
    output logic              chop_pulse,
    output logic [7:0]        drop_count
);

    localparam int C_MAXP  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int C_CNT_W = (C_MAXP > 1) ? $clog2(C_MAXP) : 1;
    localparam logic [C_CNT_W-1:0] C_DELAY_LD = C_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [C_CNT_W-1:0] C_RATE_LD  = C_CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t               r_state, w_state_nx;
    logic [1:0]           r_hdir, w_hdir_nx;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic                 r_vsync_q, r_chop_q;
    logic                 r_move_valid;
    logic [1:0]           r_move_dir;
    logic                 w_tick, w_sel_valid, w_gen;
    logic [1:0]           w_sel_dir, w_gen_dir;

    assign mv.move_valid = r_move_valid;
    assign mv.move_dir   = r_move_dir;

    assign w_tick      = vsync & ~r_vsync_q;
    assign w_sel_valid = up | down | left | right;

    always_comb begin
        w_sel_dir = 2'd3;
        if (up)        w_sel_dir = 2'd0;
        else if (down) w_sel_dir = 2'd1;
        else if (left) w_sel_dir = 2'd2;
    end

    // Edge-detect registers reset high so levels already high at release are not edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_q  <= 1'b1;
            r_chop_q   <= 1'b1;
            chop_pulse <= 1'b0;
        end else begin
            r_vsync_q  <= vsync;
            r_chop_q   <= chop;
            chop_pulse <= chop & ~r_chop_q & ~pause;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_hdir  <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_hdir  <= w_hdir_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_hdir_nx  = r_hdir;
        w_cnt_nx   = r_cnt;
        w_gen      = 1'b0;
        w_gen_dir  = w_sel_dir;
        if (w_tick && !pause) begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_valid) begin
                        w_gen      = 1'b1;
                        w_hdir_nx  = w_sel_dir;
                        w_cnt_nx   = C_DELAY_LD;
                        w_state_nx = S_DELAY;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (!w_sel_valid) begin
                        w_state_nx = S_IDLE;
                    end else if (w_sel_dir != r_hdir) begin
                        w_gen      = 1'b1;
                        w_hdir_nx  = w_sel_dir;
                        w_cnt_nx   = C_DELAY_LD;
                        w_state_nx = S_DELAY;
                    end else if (r_cnt == '0) begin
                        w_gen      = 1'b1;
                        w_gen_dir  = r_hdir;
                        w_cnt_nx   = C_RATE_LD;
                        w_state_nx = S_REPEAT;
                    end else begin
                        w_cnt_nx   = r_cnt - 1'b1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Newest step wins; an overwrite of an unaccepted entry counts as a drop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_move_valid     <= 1'b0;
            r_move_dir       <= 2'd0;
            player_direction <= 2'd0;
            drop_count       <= 8'd0;
        end else begin
            if (w_gen) begin
                r_move_valid     <= 1'b1;
                r_move_dir       <= w_gen_dir;
                player_direction <= w_gen_dir;
                if (r_move_valid && !mv.move_ready && drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end else if (r_move_valid && mv.move_ready) begin
                r_move_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
